// File: rtl/dac_seg_ctrl.sv
// dac_seg_ctrl
// ------------
// Sequencer and segmenting encoder for a segmented current-steering DAC
// driver cell. Incoming unsigned codes are clamped to the full-scale value
// and split into a binary LSB word and a thermometric MSB word. The
// thermometer units can be rotated with data-weighted averaging (DWA).
// The block also runs the power-up and power-down sequence of the
// analog cell through pdb.
//
// Handshake: a sample moves when code_valid & code_ready & enable are all
// high on a rising clk edge. code_ready is high only while in RUN. The
// producer holds code stable while code_valid is high and not yet accepted.
// The sample appears on datain/datatherm on the cycle after it is accepted.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   enable      level request to power up and run the DAC
//   dwa_en      1 = rotate thermometer units, 0 = fixed fill from unit 0
//   code        unsigned sample code
//   code_valid  sample present
//   code_ready  sink ready (RUN only)
//   datain      binary LSB segment, datainb its complement
//   datatherm   thermometric segment, datathermb its complement
//   pdb         power-down-bar to the analog cell
//   state       0 OFF, 1 PWRUP, 2 RUN, 3 PWRDN
//   clip        one-cycle pulse: accepted sample was saturated
//   underrun    one-cycle pulse: a RUN cycle had no valid sample
module dac_seg_ctrl #(
    parameter int NBIN      = 7,
    parameter int NTHERM    = 17,
    parameter int CODE_W    = 12,
    parameter int PWRUP_CYC = 16,
    parameter int PWRDN_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              dwa_en,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [NBIN-1:0]   datain,
    output logic [NBIN-1:0]   datainb,
    output logic [NTHERM-1:0] datatherm,
    output logic [NTHERM-1:0] datathermb,
    output logic              pdb,
    output logic [1:0]        state,
    output logic              clip,
    output logic              underrun
);

    localparam int CODE_MAX = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;
    localparam int M_W      = $clog2(NTHERM + 1);
    localparam int PTR_W    = $clog2(NTHERM);
    localparam int SUM_W    = M_W + 1;
    localparam int CNT_MAX  = (PWRUP_CYC > PWRDN_CYC) ? PWRUP_CYC : PWRDN_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PWRUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_PWRDN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NBIN-1:0]     datain_q, datain_d;
    logic [NBIN-1:0]     datainb_q;
    logic [NTHERM-1:0]   therm_q, therm_d;
    logic [NTHERM-1:0]   thermb_q;
    logic                pdb_q, pdb_d;
    logic                ready_q, ready_d;
    logic                clip_q, clip_d;
    logic                underrun_q, underrun_d;

    // Sample decode: clamp, split and map to thermometer units.
    logic                over_range;
    logic [CODE_W-1:0]   clamped;
    logic [M_W-1:0]      msb_units;
    logic [NBIN-1:0]     lsb_word;
    logic [NTHERM-1:0]   fill_mask;
    logic [2*NTHERM-1:0] rot_wide;
    logic [NTHERM-1:0]   rot_mask;
    logic [SUM_W-1:0]    ptr_sum;
    logic [PTR_W-1:0]    ptr_next;

    always_comb begin
        over_range = (code > CODE_W'(CODE_MAX));
        clamped    = over_range ? CODE_W'(CODE_MAX) : code;
        msb_units  = M_W'(clamped >> NBIN);
        lsb_word   = clamped[NBIN-1:0];

        // Units 0..M-1; a full-scale M would overflow the shift, so it is
        // handled as all ones.
        if (msb_units >= M_W'(NTHERM)) begin
            fill_mask = {NTHERM{1'b1}};
        end else begin
            fill_mask = (NTHERM'(1) << msb_units) - NTHERM'(1);
        end

        // Rotate left by ptr modulo NTHERM: shift into a double-width word
        // and fold the overflow half back onto the low units.
        rot_wide = {{NTHERM{1'b0}}, fill_mask} << ptr_q;
        rot_mask = rot_wide[NTHERM-1:0] | rot_wide[2*NTHERM-1:NTHERM];

        // ptr + M is at most 2*NTHERM-1, so one conditional subtract is a
        // full modulo. M = NTHERM therefore leaves ptr where it was.
        ptr_sum = SUM_W'(ptr_q) + SUM_W'(msb_units);
        if (ptr_sum >= SUM_W'(NTHERM)) begin
            ptr_next = PTR_W'(ptr_sum - SUM_W'(NTHERM));
        end else begin
            ptr_next = PTR_W'(ptr_sum);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        datain_d   = datain_q;
        therm_d    = therm_q;
        clip_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                datain_d = '0;
                therm_d  = '0;
                if (enable) begin
                    state_d = ST_PWRUP;
                    cnt_d   = CNT_W'(PWRUP_CYC - 1);
                    ptr_d   = '0;
                end
            end

            ST_PWRUP: begin
                datain_d = '0;
                therm_d  = '0;
                if (!enable) begin
                    state_d = ST_OFF;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    // A sample offered in this cycle is dropped; outputs
                    // go quiet with the transition.
                    state_d  = ST_PWRDN;
                    cnt_d    = CNT_W'(PWRDN_CYC - 1);
                    datain_d = '0;
                    therm_d  = '0;
                end else if (code_valid && ready_q) begin
                    datain_d = lsb_word;
                    clip_d   = over_range;
                    if (dwa_en) begin
                        therm_d = rot_mask;
                        ptr_d   = ptr_next;
                    end else begin
                        therm_d = fill_mask;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end

            ST_PWRDN: begin
                datain_d = '0;
                therm_d  = '0;
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_OFF;
                datain_d = '0;
                therm_d  = '0;
            end
        endcase

        pdb_d   = (state_d != ST_OFF);
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            ptr_q      <= '0;
            datain_q   <= '0;
            datainb_q  <= '1;
            therm_q    <= '0;
            thermb_q   <= '1;
            pdb_q      <= 1'b0;
            ready_q    <= 1'b0;
            clip_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            datain_q   <= datain_d;
            // Complements are registered from the same next value so the
            // true/b pair never disagrees in any cycle.
            datainb_q  <= ~datain_d;
            therm_q    <= therm_d;
            thermb_q   <= ~therm_d;
            pdb_q      <= pdb_d;
            ready_q    <= ready_d;
            clip_q     <= clip_d;
            underrun_q <= underrun_d;
        end
    end

    assign code_ready = ready_q;
    assign datain     = datain_q;
    assign datainb    = datainb_q;
    assign datatherm  = therm_q;
    assign datathermb = thermb_q;
    assign pdb        = pdb_q;
    assign state      = state_q;
    assign clip       = clip_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_seg_ctrl.sv
// Directed bench for dac_seg_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_dac_seg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        dwa_en;
    logic [11:0] code;
    logic        code_valid;
    logic        code_ready;
    logic [6:0]  datain;
    logic [6:0]  datainb;
    logic [16:0] datatherm;
    logic [16:0] datathermb;
    logic        pdb;
    logic [1:0]  state;
    logic        clip;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_seg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .dwa_en     (dwa_en),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .pdb        (pdb),
        .state      (state),
        .clip       (clip),
        .underrun   (underrun)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; dwa_en = 1'b0; code = '0; code_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (pdb !== 1'b0) begin errors++; $display("FAIL reset_pdb got %b exp 0", pdb); end
        checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", code_ready); end
        checks++; if (datain !== 7'h00 || datainb !== 7'h7F) begin errors++; $display("FAIL reset_datain got %h/%h exp 00/7f", datain, datainb); end
        checks++; if (datatherm !== 17'h0 || datathermb !== 17'h1FFFF) begin errors++; $display("FAIL reset_therm got %h/%h exp 0/1ffff", datatherm, datathermb); end
        checks++; if (clip !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got clip=%b underrun=%b exp 0/0", clip, underrun); end
    endtask

    task automatic test_powerup();
        int n = 0;
        enable = 1'b1;
        tick();
        checks++; if (state !== 2'd1 || pdb !== 1'b1) begin errors++; $display("FAIL pwrup_entry got state=%0d pdb=%b exp 1/1", state, pdb); end
        while (code_ready !== 1'b1 && n < 100) begin
            checks++;
            if (datain !== 7'h00 || datainb !== 7'h7F || datatherm !== 17'h0 || datathermb !== 17'h1FFFF || pdb !== 1'b1) begin
                errors++; $display("FAIL pwrup_outputs cycle %0d got %h %h %h %h pdb=%b exp 00 7f 0 1ffff pdb=1", n, datain, datainb, datatherm, datathermb, pdb);
            end
            tick();
            n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL pwrup_length got %0d cycles exp 16", n); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_state got %0d exp 2", state); end
        checks++; if (datain !== 7'h00 || datatherm !== 17'h0) begin errors++; $display("FAIL run_first_zero got %h %h exp 00 0", datain, datatherm); end
    endtask

    task automatic test_fixed();
        dwa_en = 1'b0; code = 12'h18F; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        checks++; if (datain !== 7'h0F || datainb !== 7'h70) begin errors++; $display("FAIL fixed_datain got %h/%h exp 0f/70", datain, datainb); end
        checks++; if (datatherm !== 17'h00007 || datathermb !== 17'h1FFF8) begin errors++; $display("FAIL fixed_therm got %h/%h exp 00007/1fff8", datatherm, datathermb); end
        checks++; if (clip !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL fixed_pulses got clip=%b underrun=%b exp 0/0", clip, underrun); end
    endtask

    task automatic test_back_to_back_dwa();
        logic [11:0] codes [4];
        logic [16:0] exp_t [4];
        codes[0] = 12'd640;  exp_t[0] = 17'h0001F; // ptr 0, M 5  -> ptr 5
        codes[1] = 12'd1792; exp_t[1] = 17'h1FFE3; // ptr 5, M 14 -> units 5..16,0,1; ptr 2
        codes[2] = 12'd384;  exp_t[2] = 17'h0001C; // ptr 2, M 3  -> ptr 5
        codes[3] = 12'd128;  exp_t[3] = 17'h00020; // ptr 5, M 1  -> unit 5
        dwa_en = 1'b1; code_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code = codes[i];
            tick();
            checks++;
            if (datatherm !== exp_t[i] || datathermb !== ~exp_t[i] || datain !== 7'h00) begin
                errors++; $display("FAIL dwa_%0d got %h/%h datain=%h exp %h/%h datain=00", i, datatherm, datathermb, datain, exp_t[i], ~exp_t[i]);
            end
        end
        code_valid = 1'b0;
    endtask

    task automatic test_clip();
        dwa_en = 1'b0; code_valid = 1'b1; code = 12'hFFF;
        tick();
        checks++; if (datatherm !== 17'h1FFFF || datain !== 7'h7F || clip !== 1'b1) begin errors++; $display("FAIL clip_over got %h %h clip=%b exp 1ffff 7f clip=1", datatherm, datain, clip); end
        code = 12'd2303;
        tick();
        code_valid = 1'b0;
        checks++; if (datatherm !== 17'h1FFFF || datain !== 7'h7F || clip !== 1'b0) begin errors++; $display("FAIL clip_max got %h %h clip=%b exp 1ffff 7f clip=0", datatherm, datain, clip); end
        checks++; if (datathermb !== 17'h0 || datainb !== 7'h00) begin errors++; $display("FAIL clip_compl got %h %h exp 0 00", datathermb, datainb); end
    endtask

    task automatic test_underrun();
        code_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (datatherm !== 17'h1FFFF || datain !== 7'h7F || underrun !== 1'b1 || code_ready !== 1'b1 || clip !== 1'b0) begin
                errors++; $display("FAIL underrun_%0d got %h %h underrun=%b ready=%b clip=%b exp 1ffff 7f 1 1 0", i, datatherm, datain, underrun, code_ready, clip);
            end
        end
    endtask

    task automatic test_powerdown();
        int n = 0;
        enable = 1'b0; code = 12'h18F; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        checks++; if (state !== 2'd3 || pdb !== 1'b1 || code_ready !== 1'b0) begin errors++; $display("FAIL pwrdn_entry got state=%0d pdb=%b ready=%b exp 3 1 0", state, pdb, code_ready); end
        checks++; if (datain !== 7'h00 || datatherm !== 17'h0 || underrun !== 1'b0) begin errors++; $display("FAIL pwrdn_zero got %h %h underrun=%b exp 00 0 0", datain, datatherm, underrun); end
        while (pdb === 1'b1 && n < 50) begin
            checks++;
            if (state !== 2'd3 || datain !== 7'h00 || datatherm !== 17'h0 || datathermb !== 17'h1FFFF) begin
                errors++; $display("FAIL pwrdn_cycle %0d got state=%0d %h %h %h exp 3 00 0 1ffff", n, state, datain, datatherm, datathermb);
            end
            enable = (n == 2);
            tick();
            n++;
        end
        enable = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL pwrdn_length got %0d cycles exp 8", n); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL pwrdn_off got %0d exp 0", state); end
        tick();
        checks++; if (state !== 2'd0 || pdb !== 1'b0) begin errors++; $display("FAIL pwrdn_stays_off got state=%0d pdb=%b exp 0 0", state, pdb); end
    endtask

    task automatic test_pwrup_abort();
        enable = 1'b1;
        tick(); tick(); tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_pre got %0d exp 1", state); end
        enable = 1'b0;
        tick();
        checks++; if (state !== 2'd0 || pdb !== 1'b0) begin errors++; $display("FAIL abort_enable got state=%0d pdb=%b exp 0 0", state, pdb); end
        enable = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; enable = 1'b0;
        checks++; if (state !== 2'd0 || pdb !== 1'b0 || code_ready !== 1'b0) begin errors++; $display("FAIL abort_reset got state=%0d pdb=%b ready=%b exp 0 0 0", state, pdb, code_ready); end
    endtask

    // Re-power with dwa: the pointer must restart from unit 0.
    task automatic test_ptr_cleared();
        int n = 0;
        enable = 1'b1;
        while (code_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL repwr_length got %0d exp 17", n); end
        dwa_en = 1'b1; code = 12'd256; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        checks++; if (datatherm !== 17'h00003) begin errors++; $display("FAIL ptr_cleared got %h exp 00003", datatherm); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_fixed();
        test_back_to_back_dwa();
        test_clip();
        test_underrun();
        test_powerdown();
        test_pwrup_abort();
        test_ptr_cleared();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
